// File: rtl/src_pkg.sv
`default_nettype none
// ============================================================================
// src_pkg : FSM state type and Galois LFSR helpers for stim_resp_checker
// Rev 1.0
// ============================================================================
package src_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  // Right-shifting Galois feedback masks giving maximal-length sequences.
  function automatic logic [15:0] lfsr_taps(input int unsigned width);
    logic [15:0] taps;
    case (width)
      2:       taps = 16'h0003;
      3:       taps = 16'h0006;
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0E08;
      13:      taps = 16'h1C80;
      14:      taps = 16'h3802;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = 16'h0000;
    endcase
    return taps;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] vec, input int unsigned width);
    logic [15:0] mask;
    logic [15:0] nxt;
    mask = (width >= 16) ? 16'hFFFF : 16'((32'd1 << width) - 32'd1);
    // A 1-bit register has only one nonzero state, so it simply holds.
    if (width < 2) begin
      return vec & mask;
    end
    nxt = (vec >> 1) ^ (vec[0] ? lfsr_taps(width) : 16'h0000);
    return nxt & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/src_vec_gen.sv
`default_nettype none
// ============================================================================
// src_vec_gen : exhaustive counter or LFSR vector source with load/step/last
// Rev 1.0
// ============================================================================
module src_vec_gen
  import src_pkg::*;
#(
  parameter int IN_W    = 2,
  parameter int MODE    = 0,
  parameter int NUM_VEC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  output logic [IN_W-1:0] vec_o,
  output logic            last_o
);

  localparam int TOTAL = (MODE == 0) ? (1 << IN_W) : NUM_VEC;
  localparam int CNT_W = (MODE == 0) ? IN_W + 1 : $clog2(NUM_VEC + 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TOTAL);
  localparam logic [IN_W-1:0]  FIRST_VEC = (MODE == 0) ? '0 : IN_W'(1);

  logic [IN_W-1:0]  vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]  w_next;

  generate
    if (MODE == 0) begin : g_count
      assign w_next = vec_q + IN_W'(1);
    end else begin : g_lfsr
      assign w_next = IN_W'(lfsr_next(16'(vec_q), IN_W));
    end
  endgenerate

  // cnt_q is the number of vectors issued so far, including the one on vec_o.
  always_comb begin
    vec_d = vec_q;
    cnt_d = cnt_q;
    if (load_i) begin
      vec_d = FIRST_VEC;
      cnt_d = CNT_W'(1);
    end else if (step_i) begin
      vec_d = w_next;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q <= '0;
      cnt_q <= '0;
    end else begin
      vec_q <= vec_d;
      cnt_q <= cnt_d;
    end
  end

  assign vec_o  = vec_q;
  assign last_o = (cnt_q == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/stim_resp_checker.sv
`default_nettype none
// ============================================================================
// stim_resp_checker : drives vectors into a DUT and golden model, compares them
// Rev 1.0
// ============================================================================
module stim_resp_checker
  import src_pkg::*;
#(
  parameter int IN_W    = 2,
  parameter int OUT_W   = 1,
  parameter int SETTLE  = 2,
  parameter int MODE    = 0,
  parameter int NUM_VEC = 16,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  output logic [IN_W-1:0]  dut_in_o,
  input  logic [OUT_W-1:0] dut_out_i,
  input  logic [OUT_W-1:0] ref_out_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_count_o,
  output logic [IN_W-1:0]  fail_vec_o,
  output logic             fail_valid_o
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  state_e           state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [IN_W-1:0]  fail_vec_q, fail_vec_d;
  logic             fail_valid_q, fail_valid_d;

  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic [IN_W-1:0]  w_vec;
  logic             w_mismatch;

  src_vec_gen #(
    .IN_W   (IN_W),
    .MODE   (MODE),
    .NUM_VEC(NUM_VEC)
  ) u_vec_gen (
    .clk   (clk),
    .rst   (rst),
    .load_i(w_load),
    .step_i(w_step),
    .vec_o (w_vec),
    .last_o(w_last)
  );

  // Case inequality so that X/Z on either side flags a mismatch in simulation.
  assign w_mismatch = (dut_out_i !== ref_out_i);

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    err_d        = err_q;
    fail_vec_d   = fail_vec_q;
    fail_valid_d = fail_valid_q;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d      = S_APPLY;
          w_load       = 1'b1;
          err_d        = '0;
          fail_vec_d   = '0;
          fail_valid_d = 1'b0;
        end
      end
      S_APPLY: begin
        settle_d = SETTLE_LOAD;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      S_SAMPLE: begin
        if (w_mismatch) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
          end
          if (!fail_valid_q) begin
            fail_vec_d   = w_vec;
            fail_valid_d = 1'b1;
          end
        end
        if (w_last) begin
          state_d = S_DONE;
        end else begin
          w_step  = 1'b1;
          state_d = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      settle_q     <= '0;
      err_q        <= '0;
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      err_q        <= err_d;
      fail_vec_q   <= fail_vec_d;
      fail_valid_q <= fail_valid_d;
    end
  end

  assign dut_in_o     = w_vec;
  assign busy_o       = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done_o       = (state_q == S_DONE);
  assign pass_o       = done_o && (err_q == '0);
  assign err_count_o  = err_q;
  assign fail_vec_o   = fail_vec_q;
  assign fail_valid_o = fail_valid_q;

endmodule
`default_nettype wire
